uart_tx_arbiter: RTL and testbench

Round-robin arbiter that shares one UART transmitter core between N_REQ byte producers, such as the receiver loopback path, a status reporter and a debug console. It latches the winning requester's byte, issues a one-cycle start to the transmitter and holds the grant until the transmitter reports frame completion. A watchdog counter recovers the arbiter if the transmitter never reports done.

---
 rtl/uart_pkg.sv | 14 +
 rtl/uart_tx_arbiter_rr_pick.sv | 45 ++++
 rtl/uart_tx_arbiter.sv | 119 +++++++++++
 tb/tb_uart_tx_arbiter.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART definitions: arbiter state encodings and default byte width
//
// Used by uart_tx_arbiter and rr_pick. The UART TX and RX blocks use the same definitions.
package uart_pkg;

  localparam int UART_DATA_W = 8;

  typedef enum logic [1:0] {
    sIDLE  = 2'b00,
    sSTART = 2'b01,
    sWAIT  = 2'b10
  } arb_state_e;

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// rtl/uart_tx_arbiter_rr_pick.sv - combinational round-robin winner search
//
// Ports:
//   req    in  N_REQ  request vector
//   ptr    in  IDX_W  first index to consider
//   valid  out 1      at least one request is set
//   idx    out IDX_W  first set request at or after ptr, wrapping modulo N_REQ
module rr_pick
  import uart_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int IDX_W = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic             valid,
  output logic [IDX_W-1:0] idx
);

  localparam logic [IDX_W:0] N_W = (IDX_W+1)'(N_REQ);

  logic [IDX_W:0]   sum;
  logic [IDX_W-1:0] cand;

  // One extra bit of headroom so ptr+i never overflows before the wrap.
  // The wrap is a compare-and-subtract, so N_REQ need not be a power of 2.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    sum   = '0;
    cand  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      sum = {1'b0, ptr} + (IDX_W+1)'(i);
      if (sum >= N_W) begin
        sum = sum - N_W;
      end
      cand = sum[IDX_W-1:0];
      if (!valid && req[cand]) begin
        valid = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin arbiter sharing one UART transmitter between N_REQ producers
//
// Ports:
//   clk_i          in  1             clock, rising edge
//   rstb_i         in  1             synchronous active-low reset
//   req_i          in  N_REQ         request levels, held until acked
//   data_i         in  N_REQ*DATA_W  packed bytes, requester k at [k*DATA_W +: DATA_W]
//   ack_o          out N_REQ         one-cycle ack to the granted requester
//   tx_start_o     out 1             one-cycle start strobe to the transmitter
//   tx_data_o      out DATA_W        latched byte of the current grant
//   tx_busy_i      in  1             transmitter busy level
//   tx_done_i      in  1             transmitter frame-complete pulse
//   grant_idx_o    out IDX_W         current or most recent grant index
//   busy_o         out 1             arbiter not idle
//   err_timeout_o  out 1             one-cycle pulse when the watchdog aborts a grant
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int N_REQ       = 4,
  parameter int DATA_W      = UART_DATA_W,
  parameter int IDX_W       = 2,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic                    clk_i,
  input  logic                    rstb_i,
  input  logic [N_REQ-1:0]        req_i,
  input  logic [N_REQ*DATA_W-1:0] data_i,
  output logic [N_REQ-1:0]        ack_o,
  output logic                    tx_start_o,
  output logic [DATA_W-1:0]       tx_data_o,
  input  logic                    tx_busy_i,
  input  logic                    tx_done_i,
  output logic [IDX_W-1:0]        grant_idx_o,
  output logic                    busy_o,
  output logic                    err_timeout_o
);

  localparam int               WD_W     = $clog2(TIMEOUT_CYC) + 1;
  localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT_CYC - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_REQ - 1);
  localparam logic [N_REQ-1:0] ONE_HOT0 = N_REQ'(1);

  arb_state_e       state;
  logic [IDX_W-1:0] rr_ptr;
  logic [WD_W-1:0]  wdog;
  logic [WD_W-1:0]  wdog_nxt;
  logic [IDX_W-1:0] ptr_after;
  logic             pick_valid;
  logic [IDX_W-1:0] pick_idx;

  rr_pick #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr_pick (
    .req   (req_i),
    .ptr   (rr_ptr),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  // The abort fires when the count is about to reach TIMEOUT_CYC-1, so
  // err_timeout_o lands TIMEOUT_CYC cycles after the start strobe.
  assign wdog_nxt  = wdog + 1'b1;
  assign ptr_after = (grant_idx_o == IDX_LAST) ? '0 : grant_idx_o + 1'b1;

  always_ff @(posedge clk_i) begin
    if (!rstb_i) begin
      state         <= sIDLE;
      rr_ptr        <= '0;
      wdog          <= '0;
      grant_idx_o   <= '0;
      tx_data_o     <= '0;
      ack_o         <= '0;
      tx_start_o    <= 1'b0;
      busy_o        <= 1'b0;
      err_timeout_o <= 1'b0;
    end else begin
      ack_o         <= '0;
      tx_start_o    <= 1'b0;
      err_timeout_o <= 1'b0;
      case (state)
        sIDLE: begin
          if (pick_valid && !tx_busy_i) begin
            grant_idx_o <= pick_idx;
            tx_data_o   <= data_i[pick_idx*DATA_W +: DATA_W];
            ack_o       <= ONE_HOT0 << pick_idx;
            tx_start_o  <= 1'b1;
            busy_o      <= 1'b1;
            state       <= sSTART;
          end
        end
        sSTART: begin
          // tx_done_i here belongs to an earlier frame and is ignored.
          wdog  <= '0;
          state <= sWAIT;
        end
        sWAIT: begin
          if (tx_done_i) begin
            rr_ptr <= ptr_after;
            busy_o <= 1'b0;
            state  <= sIDLE;
          end else if (wdog_nxt == WD_LAST) begin
            err_timeout_o <= 1'b1;
            rr_ptr        <= ptr_after;
            busy_o        <= 1'b0;
            state         <= sIDLE;
          end else begin
            wdog <= wdog_nxt;
          end
        end
        default: begin
          busy_o <= 1'b0;
          state  <= sIDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - self-checking bench for uart_tx_arbiter
module tb_uart_tx_arbiter;

  localparam int N_REQ       = 4;
  localparam int DATA_W      = 8;
  localparam int IDX_W       = 2;
  localparam int TIMEOUT_CYC = 16;

  logic        clk = 1'b0;
  logic        rstb_i;
  logic [3:0]  req_i;
  logic [31:0] data_i;
  logic [3:0]  ack_o;
  logic        tx_start_o;
  logic [7:0]  tx_data_o;
  logic        tx_busy_i;
  logic        tx_done_i;
  logic [1:0]  grant_idx_o;
  logic        busy_o;
  logic        err_timeout_o;

  uart_tx_arbiter #(
    .N_REQ       (N_REQ),
    .DATA_W      (DATA_W),
    .IDX_W       (IDX_W),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .clk_i         (clk),
    .rstb_i        (rstb_i),
    .req_i         (req_i),
    .data_i        (data_i),
    .ack_o         (ack_o),
    .tx_start_o    (tx_start_o),
    .tx_data_o     (tx_data_o),
    .tx_busy_i     (tx_busy_i),
    .tx_done_i     (tx_done_i),
    .grant_idx_o   (grant_idx_o),
    .busy_o        (busy_o),
    .err_timeout_o (err_timeout_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] idx;
    logic [7:0] data;
  } exp_t;

  typedef struct {
    logic [3:0]  req;
    logic [31:0] data;
    logic [1:0]  exp_idx;
    int          done_dly;
  } vec_t;

  exp_t sb[$];
  exp_t mon_e;
  vec_t vecs[9];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
  endtask

  task automatic push_exp(input logic [1:0] idx, input logic [7:0] d);
    exp_t e;
    e.idx  = idx;
    e.data = d;
    sb.push_back(e);
  endtask

  // Scoreboard: every start strobe must match the next expected grant.
  always @(negedge clk) begin
    if (rstb_i === 1'b1) begin
      if (tx_start_o) begin
        if (sb.size() == 0) begin
          check("unexpected_start", 32'd1, 32'd0);
        end else begin
          mon_e = sb.pop_front();
          check("grant_idx", grant_idx_o, mon_e.idx);
          check("tx_data", tx_data_o, mon_e.data);
          check("ack_onehot", ack_o, 32'd1 << mon_e.idx);
        end
      end else begin
        check("ack_without_start", ack_o, 32'd0);
      end
    end
  end

  task automatic wait_start(input string name);
    int k;
    for (k = 0; k < 40; k++) begin
      @(negedge clk);
      if (tx_start_o) break;
    end
    check(name, k < 40, 1);
  endtask

  task automatic pulse_done();
    tx_done_i = 1'b1;
    @(negedge clk);
    tx_done_i = 1'b0;
    check("busy_after_done", busy_o, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ack"}, ack_o, 0);
    check({tag, "_start"}, tx_start_o, 0);
    check({tag, "_busy"}, busy_o, 0);
    check({tag, "_err"}, err_timeout_o, 0);
    check({tag, "_grant"}, grant_idx_o, 0);
    check({tag, "_txdata"}, tx_data_o, 0);
  endtask

  task automatic run_vec(input vec_t v);
    @(negedge clk);
    req_i  = v.req;
    data_i = v.data;
    push_exp(v.exp_idx, v.data[v.exp_idx*8 +: 8]);
    @(negedge clk);
    check("start_latency", tx_start_o, 1);
    check("busy_in_start", busy_o, 1);
    req_i = 4'b0000;
    repeat (v.done_dly) @(negedge clk);
    check("busy_before_done", busy_o, 1);
    pulse_done();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int k;
    // Expected winners follow the round-robin pointer carried across rows.
    vecs[0] = '{4'b0010, 32'h0000A500, 2'd1, 1};  // ptr 0 -> 1, ptr becomes 2
    vecs[1] = '{4'b1010, 32'h44332211, 2'd3, 2};  // ptr 2 -> 3
    vecs[2] = '{4'b1010, 32'h88776655, 2'd1, 3};  // ptr 0 -> 1
    vecs[3] = '{4'b0011, 32'h0C0B0A09, 2'd0, 1};  // ptr 2 -> wrap to 0
    vecs[4] = '{4'b1001, 32'hF0E0D0C0, 2'd3, 5};  // ptr 1 -> 3
    vecs[5] = '{4'b0110, 32'h13579BDF, 2'd1, 1};  // ptr 0 -> 1
    vecs[6] = '{4'b1101, 32'h2468ACE0, 2'd2, 2};  // ptr 2 -> 2
    vecs[7] = '{4'b1111, 32'h5A6B7C8D, 2'd3, 1};  // ptr 3 -> 3
    vecs[8] = '{4'b0010, 32'h00990000, 2'd1, 4};  // ptr 0 -> 1, ptr becomes 2

    rstb_i    = 1'b0;
    req_i     = 4'b0000;
    data_i    = 32'h0;
    tx_busy_i = 1'b0;
    tx_done_i = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rstb_i = 1'b1;

    foreach (vecs[i]) run_vec(vecs[i]);

    // Reset in sWAIT with all requesting: outputs clear and pointer returns to 0.
    @(negedge clk);
    req_i  = 4'b1111;
    data_i = 32'hD4C3B2A1;
    push_exp(2'd2, 8'hC3);
    wait_start("rst_pre_start");
    repeat (3) @(negedge clk);
    check("rst_pre_busy", busy_o, 1);
    rstb_i = 1'b0;
    @(negedge clk);
    check_reset_outputs("midreset");
    push_exp(2'd0, 8'hA1);
    push_exp(2'd1, 8'hB2);
    push_exp(2'd2, 8'hC3);
    push_exp(2'd3, 8'hD4);
    push_exp(2'd0, 8'hA1);
    push_exp(2'd1, 8'hB2);
    rstb_i = 1'b1;

    // Continuous requests from everyone, done 10 cycles after each start.
    for (int g = 0; g < 6; g++) begin
      wait_start("rr_start");
      if (g == 5) req_i = 4'b0000;
      repeat (10) @(negedge clk);
      pulse_done();
    end

    // Transmitter busy holds off arbitration.
    @(negedge clk);
    tx_busy_i = 1'b1;
    req_i     = 4'b0001;
    data_i    = 32'h0000005A;
    push_exp(2'd0, 8'h5A);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("no_start_while_busy", tx_start_o, 0);
    end
    tx_busy_i = 1'b0;
    @(negedge clk);
    check("start_after_busy", tx_start_o, 1);
    req_i = 4'b0000;
    repeat (2) @(negedge clk);
    pulse_done();

    // Watchdog abort with no done.
    @(negedge clk);
    req_i  = 4'b0100;
    data_i = 32'h00C30000;
    push_exp(2'd2, 8'hC3);
    wait_start("to_start");
    req_i = 4'b0000;
    for (k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (err_timeout_o) break;
    end
    check("timeout_cycles", k, TIMEOUT_CYC);
    check("busy_at_err", busy_o, 0);
    @(negedge clk);
    check("err_one_cycle", err_timeout_o, 0);
    req_i  = 4'b1101;
    data_i = 32'h77000000;
    push_exp(2'd3, 8'h77);
    wait_start("after_to_start");
    req_i = 4'b0000;
    repeat (2) @(negedge clk);
    pulse_done();

    // Done during sSTART is ignored; only the later done ends the grant.
    @(negedge clk);
    req_i  = 4'b0010;
    data_i = 32'h00007E00;
    push_exp(2'd1, 8'h7E);
    wait_start("dis_start");
    tx_done_i = 1'b1;
    req_i     = 4'b0000;
    @(negedge clk);
    tx_done_i = 1'b0;
    check("early_done_ignored", busy_o, 1);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      check("busy_until_done", busy_o, 1);
    end
    @(negedge clk);
    pulse_done();

    repeat (3) @(negedge clk);
    check("sb_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
